// File: rtl/led_matrix_scanner.sv
// 8-column LED bar-graph scanner with peak-hold dots.
// Frames latch into a shadow and are applied only at the scan wrap.
module led_matrix_scanner #(
  parameter int ROWS        = 8,
  parameter int DWELL       = 1024,
  parameter int BLANK       = 16,
  parameter int HOLD_FRAMES = 32,
  parameter int PEAK_EN     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mag_valid,
  input  logic [31:0]     mag_bus,
  output logic [2:0]      led_select,
  output logic [ROWS-1:0] led_rows,
  output logic            frame_sync
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(ROWS + 1);
  localparam int HW   = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_sel, w_sel_nxt;
  logic            r_sync, w_sync_nxt;

  logic [31:0]     r_shadow;
  logic            r_pending;
  logic [31:0]     r_disp;
  logic [PW-1:0]   r_peak [8];
  logic [HW-1:0]   r_hold [8];

  logic            w_apply;
  logic [31:0]     w_frame;
  logic [PW-1:0]   w_lvl_new [8];
  logic [PW-1:0]   w_lvl_cur;
  logic [PW-1:0]   w_pk_cur;
  logic [ROWS-1:0] w_pat;

  function automatic logic [PW-1:0] lvl_of(input logic [3:0] m);
    if (int'(m) > ROWS) return PW'(ROWS);
    return PW'(m);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_sync  <= w_sync_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_sel_nxt   = r_sel;
    w_sync_nxt  = 1'b0;
    unique case (r_state)
      S_BLANK: begin
        if (r_cnt == CW'(BLANK - 1)) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == CW'(DWELL - 1)) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_sel_nxt   = r_sel + 3'd1;
          w_sync_nxt  = (r_sel == 3'd7);
        end
      end
      default: begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // r_sync marks the boundary cycle; a strobe in it bypasses the shadow
  assign w_apply = r_sync && (mag_valid || r_pending);
  assign w_frame = mag_valid ? mag_bus : r_shadow;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_lvl_new[k] = lvl_of(w_frame[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_disp    <= '0;
      for (int k = 0; k < 8; k++) begin
        r_peak[k] <= '0;
        r_hold[k] <= '0;
      end
    end else begin
      if (mag_valid) begin
        r_shadow  <= mag_bus;
        r_pending <= 1'b1;
      end
      if (w_apply) begin
        r_disp    <= w_frame;
        r_pending <= 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (w_lvl_new[k] >= r_peak[k]) begin
            r_peak[k] <= w_lvl_new[k];
            r_hold[k] <= HW'(HOLD_FRAMES - 1);
          end else if (r_hold[k] != '0) begin
            r_hold[k] <= r_hold[k] - HW'(1);
          end else begin
            r_peak[k] <= r_peak[k] - PW'(1);
          end
        end
      end
    end
  end

  assign w_lvl_cur = lvl_of(r_disp[{r_sel, 2'b00} +: 4]);
  assign w_pk_cur  = r_peak[r_sel];

  always_comb begin
    w_pat = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_pat[i] = (i < int'(w_lvl_cur)) ||
                 ((PEAK_EN != 0) && (int'(w_pk_cur) == i + 1));
    end
  end

  assign led_select = r_sel;
  assign led_rows   = (r_state == S_DRIVE) ? w_pat : '0;
  assign frame_sync = r_sync;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: timeline model from the scan period,
// frame/peak model in plain integers, random strobes plus pinned literals.
module tb_led_matrix_scanner;

  localparam int ROWS = 8;
  localparam int DW   = 4;
  localparam int BL   = 2;
  localparam int HF   = 2;
  localparam int COLT = DW + BL;
  localparam int SCAN = 8 * COLT;

  logic        clk;
  logic        rst_n;
  logic        mag_valid;
  logic [31:0] mag_bus;
  logic [2:0]  led_select;
  logic [7:0]  led_rows;
  logic        frame_sync;

  int total = 0;
  int bad   = 0;

  led_matrix_scanner #(
    .ROWS(ROWS), .DWELL(DW), .BLANK(BL),
    .HOLD_FRAMES(HF), .PEAK_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mag_valid(mag_valid), .mag_bus(mag_bus),
    .led_select(led_select), .led_rows(led_rows),
    .frame_sync(frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // behavioural model
  int t = 0;
  int m_lvl [8];
  int m_pk [8];
  int m_hold [8];
  logic [31:0] m_shadow;
  bit m_pend;

  function automatic int pat(input int lvl, input int pk);
    int p;
    p = (1 << lvl) - 1;
    if (pk > 0) p = p | (1 << (pk - 1));
    return p & 8'hFF;
  endfunction

  task automatic model_clear();
    t = 0;
    m_shadow = '0;
    m_pend = 0;
    for (int k = 0; k < 8; k++) begin
      m_lvl[k] = 0; m_pk[k] = 0; m_hold[k] = 0;
    end
  endtask

  task automatic model_apply(input logic [31:0] f);
    for (int k = 0; k < 8; k++) begin
      int v;
      v = int'((f >> (4 * k)) & 32'hF);
      if (v > ROWS) v = ROWS;
      m_lvl[k] = v;
      if (v >= m_pk[k]) begin
        m_pk[k] = v; m_hold[k] = HF - 1;
      end else if (m_hold[k] != 0) begin
        m_hold[k]--;
      end else begin
        m_pk[k]--;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rows", 32'(led_rows), 32'd0);
      check("rst_sel", 32'(led_select), 32'd0);
      check("rst_sync", 32'(frame_sync), 32'd0);
      model_clear();
    end else begin
      int pos, col, ph, er;
      bit es;
      pos = t % SCAN;
      col = pos / COLT;
      ph  = pos % COLT;
      er  = (ph < BL) ? 0 : pat(m_lvl[col], m_pk[col]);
      es  = (pos == 0) && (t >= SCAN);
      check("sel", 32'(led_select), 32'(col));
      check("rows", 32'(led_rows), 32'(er));
      check("sync", 32'(frame_sync), 32'(es));
      if (es && (mag_valid || m_pend)) begin
        model_apply(mag_valid ? mag_bus : m_shadow);
        if (mag_valid) m_shadow = mag_bus;
        m_pend = 0;
      end else if (mag_valid) begin
        m_shadow = mag_bus;
        m_pend = 1;
      end
      t++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    for (int n = 0; n < 4 * SCAN; n++) begin
      if ((t % SCAN) == p) return;
      tick();
    end
    check("wait_pos_timeout", 32'd1, 32'd0);
  endtask

  task automatic strobe(input logic [31:0] v);
    mag_valid = 1'b1;
    mag_bus   = v;
    tick();
    mag_valid = 1'b0;
    mag_bus   = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    mag_valid = 1'b0;
    mag_bus = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("first_sel", 32'(led_select), 32'd0);
    check("first_sync", 32'(frame_sync), 32'd0);

    // idle scans: rows stay dark
    repeat (2 * SCAN + 5) tick();

    // mid-scan frame shows after the wrap
    wait_pos(20);
    strobe(32'h8765_4321);
    wait_pos(0);
    wait_pos(3);
    check("col0_lit", 32'(led_rows), 32'h01);
    wait_pos(3 * COLT + 3);
    check("col3_lit", 32'(led_rows), 32'h0F);
    wait_pos(7 * COLT + 3);
    check("col7_lit", 32'(led_rows), 32'hFF);

    // clamp and peak hold
    wait_pos(10);
    strobe(32'h0000_000F);
    wait_pos(3);
    check("clamp_lit", 32'(led_rows), 32'hFF);
    wait_pos(10);
    strobe(32'h0000_0002);
    wait_pos(3);
    check("hold_lit", 32'(led_rows), 32'h83);
    for (int f = 0; f < 10; f++) begin
      wait_pos(10);
      strobe(32'h0000_0002);
    end
    wait_pos(3);
    check("decay_lit", 32'(led_rows), 32'h03);

    // latest strobe wins; strobe in boundary cycle is shown at once
    wait_pos(10);
    strobe(32'h0000_0001);
    wait_pos(30);
    strobe(32'h0000_0005);
    wait_pos(3);
    check("latest_lit", 32'(led_rows), 32'h1F);
    wait_pos(0);
    strobe(32'h0000_0003);
    wait_pos(3);
    check("bypass_lit", 32'(led_rows), 32'h17);

    // random traffic
    for (int n = 0; n < 12 * SCAN; n++) begin
      if ($urandom_range(0, 19) == 0) strobe($urandom);
      else tick();
    end

    // reset during col5 drive with a frame pending
    wait_pos(5 * COLT + 3);
    strobe(32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    check("arst_rows", 32'(led_rows), 32'd0);
    check("arst_sel", 32'(led_select), 32'd0);
    check("arst_sync", 32'(frame_sync), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2 * SCAN + 3) tick();
    wait_pos(3);
    check("discard_lit", 32'(led_rows), 32'd0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
